// File: rtl/fifo36k_sync_ctrl_pkg.sv
// Shared types and defaults for the FIFO36K sharing controller.
//   state_e          : controller state (flush sequencing vs. normal run)
//   FIFO_DW          : default FIFO word width
//   FLUSH_CYCLES_DEF : default number of cycles fifo_rst is held per flush
package fifo36k_ctrl_pkg;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int FIFO_DW          = 36;
  localparam int FLUSH_CYCLES_DEF = 5;

endpackage

// File: rtl/fifo36k_sync_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester found searching
// cyclically from ptr_i+1. Purely combinational.
//   req_i   : request vector
//   en_i    : global enable; no grant when low
//   ptr_i   : index of the last granted requester
//   grant_o : one-hot grant
//   idx_o   : index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       en_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o
);

  localparam int IW = $clog2(NUM_REQ);

  always_comb begin
    int j;
    grant_o = '0;
    idx_o   = '0;
    j       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (en_i && (grant_o == '0) && req_i[j]) begin
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo36k_sync_ctrl.sv
// Shares one synchronous FIFO36K primitive between NUM_REQ valid/ready
// writers and a single valid/ready consumer, and sequences FIFO flush.
//   clk, rst                  : clock, async active-high reset
//   flush_req                 : pulse, (re)starts a flush sequence
//   req_valid/req_data/req_ready : writer side, one-hot round-robin grant
//   out_valid/out_data/out_ready : consumer side, fed by a 2-entry prefetch buffer
//   fifo_*                    : FIFO36K primitive interface
//   busy                      : high while flushing
//   err_ovf, err_unf          : sticky FIFO error flags, cleared by flush
//
// state    | meaning
// ST_FLUSH | fifo_rst held, datapath idle and cleared, counts FLUSH_CYCLES
// ST_RUN   | arbitration, prefetch and error capture active
module fifo36k_sync_ctrl
  import fifo36k_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = FIFO_DW,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_req,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  output logic                          fifo_rst,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_push,
  output logic                          fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]         fifo_pop,
  input  logic                          fifo_empty,
  input  logic                          fifo_almost_empty,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  input  logic                          fifo_overflow,
  input  logic                          fifo_underflow,
  output logic                          busy,
  output logic                          err_ovf,
  output logic                          err_unf
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           fcnt_q, fcnt_d;
  logic [IW-1:0]           rr_q, rr_d, gnt_idx;
  logic [NUM_REQ-1:0]      gnt;
  logic                    wr_last_q, inflight_q, inflight_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   buf0_q, buf0_d, buf1_q, buf1_d;
  logic                    err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;
  logic                    run, write_ok, read_ok, pop_now, wr_xfer, rd_en;
  logic [2:0]              occ;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FLUSH;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_FLUSH: begin
        if (flush_req) begin
          fcnt_d = '0;
        end else if (fcnt_q == CW'(FLUSH_CYCLES - 1)) begin
          state_d = ST_RUN;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        if (flush_req) begin
          state_d = ST_FLUSH;
          fcnt_d  = '0;
        end
      end
      default: begin
        state_d = ST_FLUSH;
        fcnt_d  = '0;
      end
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    run      = 1'b0;
    fifo_rst = 1'b1;
    busy     = 1'b1;
    if (state_q == ST_RUN) begin
      run      = 1'b1;
      fifo_rst = 1'b0;
      busy     = 1'b0;
    end
  end

  // ---------------- write side ----------------
  // Almost-full right after a write may already be one behind the real
  // fill level, so hold off one cycle in that case.
  assign write_ok = !fifo_full && !(fifo_almost_full && wr_last_q);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .req_i   (req_valid),
    .en_i    (run && write_ok),
    .ptr_i   (rr_q),
    .grant_o (gnt),
    .idx_o   (gnt_idx)
  );

  assign req_ready  = gnt;
  assign wr_xfer    = |(req_valid & gnt);
  assign fifo_wr_en = wr_xfer;
  assign fifo_push  = wr_xfer ? req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign rr_d       = wr_xfer ? gnt_idx : rr_q;

  // ---------------- read side ----------------
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = buf0_q;
  assign pop_now   = out_valid && out_ready;
  assign read_ok   = !fifo_empty && !(fifo_almost_empty && inflight_q);
  // Occupancy the buffer will have once the outstanding read lands.
  assign occ       = 3'(cnt_q) + 3'(inflight_q) - 3'(pop_now);
  assign rd_en     = run && read_ok && (occ < 3'd2);
  assign fifo_rd_en = rd_en;

  always_comb begin
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    cnt_d      = cnt_q;
    inflight_d = rd_en;
    if (state_d == ST_FLUSH) begin
      cnt_d      = 2'd0;
      inflight_d = 1'b0;
    end else begin
      case ({pop_now, inflight_q})
        2'b10: begin
          buf0_d = buf1_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd0) buf0_d = fifo_pop;
          else               buf1_d = fifo_pop;
          cnt_d = cnt_q + 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            buf0_d = fifo_pop;
          end else begin
            buf0_d = buf1_q;
            buf1_d = fifo_pop;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- errors ----------------
  assign err_ovf_d = (state_d == ST_FLUSH) ? 1'b0 : (err_ovf_q || (run && fifo_overflow));
  assign err_unf_d = (state_d == ST_FLUSH) ? 1'b0 : (err_unf_q || (run && fifo_underflow));
  assign err_ovf   = err_ovf_q;
  assign err_unf   = err_unf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= IW'(NUM_REQ - 1);
      wr_last_q  <= 1'b0;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      err_ovf_q  <= 1'b0;
      err_unf_q  <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      wr_last_q  <= wr_xfer;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      err_ovf_q  <= err_ovf_d;
      err_unf_q  <= err_unf_d;
    end
  end

endmodule
